rv32_fetch_decode_exec: RTL and testbench
=========================================

Name: rv32_fetch_decode_exec

Overview:
- Single-cycle RV32I + Zicsr front end and ALU for the ysyx core.
- Holds the PC register and presents the fetch address.
- Decodes the returned instruction word and computes the ALU/address result, branch/jump target and CSR write value.
- Register file, LSU, trap sequencing and memory live outside; they feed operands in and consume results combinationally in the same cycle.

Parameters:
- RESET_PC, 32'h8000_0000, PC value after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- advance  in  1  PC update enable (core not stalled).
- imem_rdata  in  32  fetched instruction word for current PC.
- rs1_data  in  32  GPR[rs1].
- rs2_data  in  32  GPR[rs2].
- csr_rdata  in  32  CSR[csr_addr].
- mepc  in  32  current MEPC.
- mtvec  in  32  current MTVEC.
- pc  out  32  current PC; also the fetch address.
- inst  out  32  instruction word (= imem_rdata).
- opcode  out  7  inst[6:0].
- funct3  out  3  inst[14:12].
- funct7  out  7  inst[31:25].
- rs1_addr  out  5  inst[19:15].
- rs2_addr  out  5  inst[24:20].
- rd_addr  out  5  inst[11:7].
- csr_addr  out  12  inst[31:20].
- imm  out  32  sign-extended immediate (I/S/B/U/J per opcode; 0 for R-type).
- is_load  out  1  valid LOAD opcode.
- is_store  out  1  valid STORE opcode.
- is_ecall  out  1  inst == 32'h0000_0073.
- inst_invalid  out  1  unrecognised encoding.
- result  out  32  ALU result / memory address / link / CSR old value.
- reg_write_en  out  1  GPR write request.
- next_pc  out  32  PC for next instruction.
- csr_we  out  1  CSR write request for Zicsr instructions.
- csr_wdata  out  32  CSR write value.

Behaviour:
- pc register: rst → RESET_PC on the next edge. Otherwise pc ← next_pc when advance=1; holds when advance=0. rst has priority.
- Everything else is combinational from pc, imem_rdata and the operand inputs; zero latency. No other state.
- Supported encodings:
  - LUI, AUIPC, JAL, JALR (funct3=0).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU, SB/SH/SW.
  - OP-IMM: all; SLLI/SRLI/SRAI also check funct7.
  - OP: all RV32I incl. SUB/SRA via funct7=0x20.
  - CSRRW/S/C and CSRRWI/SI/CI.
  - ECALL (0x00000073), EBREAK (0x00100073), MRET (0x30200073).
  - Anything else → inst_invalid=1.
- result:
  - LUI: imm.
  - AUIPC: pc+imm.
  - JAL/JALR: pc+4.
  - Load/store: rs1+imm.
  - ALU: op result; shifts use the low 5 bits; SLT/SLTU yield 0/1.
  - CSR ops: csr_rdata.
  - Branch/system/invalid: 0.
- reg_write_en: 1 for LUI, AUIPC, JAL, JALR, load, OP, OP-IMM and CSR ops, and only when rd_addr≠0 and !inst_invalid. Otherwise 0.
- next_pc:
  - JAL: pc+imm.
  - JALR: (rs1+imm) & ~1.
  - Taken branch: pc+imm; untaken: pc+4. Signed compares for BLT/BGE, unsigned for BLTU/BGEU.
  - ECALL: mtvec.
  - MRET: mepc.
  - All else, including invalid and EBREAK: pc+4.
- csr_wdata (zimm = rs1_addr zero-extended; src = rs1_data for register forms, zimm for I forms):
  - W forms: src.
  - S forms: csr_rdata | src.
  - C forms: csr_rdata & ~src.
- csr_we: 1 for CSRRW/CSRRWI always; for S/C forms only when the rs1 field ≠ 0; 0 for ECALL/MRET/others. Trap-cause/MEPC writes are done by the core, not here.
- inst_invalid forces reg_write_en=0, csr_we=0, is_load=0, is_store=0, next_pc=pc+4.
- Arithmetic is 32-bit modulo 2^32; wrap-around is silent.

Decomposition:
- Shared package: opcode constants (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, SYSTEM 1110011), CSR addresses (MEPC 0x341, MCAUSE 0x342, MTVEC 0x305, MSTATUS 0x300), RESET_PC.
- One sub-module: rv32_decoder (fields, immediate, class flags, inst_invalid). ALU and next-PC logic stay in the top.

Test Plan:
- Reset then advance=1 with imem_rdata=0x00500093 (addi x1,x0,5) → pc=0x80000000 during rst; result=5, rd=1, reg_write_en=1, next_pc=0x80000004; pc=0x80000004 after one edge.
- advance=0 for 3 cycles → pc holds its value.
- beq x1,x2,+8 (0x00208463): with rs1=rs2=7 → next_pc=pc+8; with rs1=7, rs2=8 → next_pc=pc+4.
- blt x1,x2,+8 (0x0020C463) with rs1=0xFFFFFFFF, rs2=1 → taken; bltu x1,x2,+8 (0x0020E463) with the same operands → not taken.
- jalr x1,4(x2) (0x004100E7) with rs1=0x80001003 → next_pc=0x80001006 (0x80001007 with bit 0 cleared), result=pc+4.
- sw x2,8(x1) (0x0020A423) with rs1=0x80000100 → result=0x80000108, is_store=1, reg_write_en=0.
- csrrs x5,mtvec,x0 → csr_we=0, result=csr_rdata.
- ecall with mtvec=0x80000400 → is_ecall=1, next_pc=0x80000400.
- mret with mepc=0x80000010 → next_pc=0x80000010.
- inst=0xFFFFFFFF → inst_invalid=1, no writes, next_pc=pc+4.

Source files
------------

// File: rtl/rv32_fetch_decode_exec_pkg.sv
// Shared constants and types for the RV32I + Zicsr fetch/decode/execute slice.
package rv32_fetch_decode_exec_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Machine-mode CSR addresses used by the surrounding core
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Fully-fixed SYSTEM encodings
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] PKG_RESET_PC = 32'h8000_0000;

  // One-hot-ish instruction class; a flag is only set for a valid encoding
  typedef struct packed {
    logic is_lui;
    logic is_auipc;
    logic is_jal;
    logic is_jalr;
    logic is_branch;
    logic is_load;
    logic is_store;
    logic is_op_imm;
    logic is_op;
    logic is_csr;
    logic is_ecall;
    logic is_ebreak;
    logic is_mret;
  } dec_class_t;

endpackage

// File: rtl/rv32_fetch_decode_exec_decoder.sv
// Instruction field extraction, immediate generation and encoding validation.
module rv32_fetch_decode_exec_decoder
  import rv32_fetch_decode_exec_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [6:0]  o_opcode,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic [11:0] o_csr_addr,
  output logic [31:0] o_imm,
  output dec_class_t  o_cls,
  output logic        o_inst_invalid
);

  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign o_opcode   = i_inst[6:0];
  assign o_funct3   = i_inst[14:12];
  assign o_funct7   = i_inst[31:25];
  assign o_rs1_addr = i_inst[19:15];
  assign o_rs2_addr = i_inst[24:20];
  assign o_rd_addr  = i_inst[11:7];
  assign o_csr_addr = i_inst[31:20];

  assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u = {i_inst[31:12], 12'b0};
  assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  // Classify by opcode, validate the minor fields and pick the immediate format
  always_comb begin
    o_cls          = '0;
    o_imm          = 32'd0;
    o_inst_invalid = 1'b0;
    case (o_opcode)
      OPC_LUI: begin
        o_cls.is_lui = 1'b1;
        o_imm        = w_imm_u;
      end
      OPC_AUIPC: begin
        o_cls.is_auipc = 1'b1;
        o_imm          = w_imm_u;
      end
      OPC_JAL: begin
        o_cls.is_jal = 1'b1;
        o_imm        = w_imm_j;
      end
      OPC_JALR: begin
        o_imm = w_imm_i;
        if (o_funct3 == 3'b000) o_cls.is_jalr = 1'b1;
        else                    o_inst_invalid = 1'b1;
      end
      OPC_BRANCH: begin
        o_imm = w_imm_b;
        // funct3 010/011 are unassigned branch encodings
        if (o_funct3[2:1] != 2'b01) o_cls.is_branch = 1'b1;
        else                        o_inst_invalid = 1'b1;
      end
      OPC_LOAD: begin
        o_imm = w_imm_i;
        if (o_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) o_cls.is_load = 1'b1;
        else                                                          o_inst_invalid = 1'b1;
      end
      OPC_STORE: begin
        o_imm = w_imm_s;
        if (o_funct3 inside {3'b000, 3'b001, 3'b010}) o_cls.is_store = 1'b1;
        else                                          o_inst_invalid = 1'b1;
      end
      OPC_OP_IMM: begin
        o_imm = w_imm_i;
        // Only the shift-immediates carry a funct7 that must be checked
        if ((o_funct3 == 3'b001 && o_funct7 != 7'h00) ||
            (o_funct3 == 3'b101 && o_funct7 != 7'h00 && o_funct7 != 7'h20))
          o_inst_invalid = 1'b1;
        else
          o_cls.is_op_imm = 1'b1;
      end
      OPC_OP: begin
        if (o_funct7 == 7'h00 ||
            (o_funct7 == 7'h20 && (o_funct3 == 3'b000 || o_funct3 == 3'b101)))
          o_cls.is_op = 1'b1;
        else
          o_inst_invalid = 1'b1;
      end
      OPC_SYSTEM: begin
        o_imm = w_imm_i;
        if (o_funct3 == 3'b000) begin
          if      (i_inst == INST_ECALL)  o_cls.is_ecall  = 1'b1;
          else if (i_inst == INST_EBREAK) o_cls.is_ebreak = 1'b1;
          else if (i_inst == INST_MRET)   o_cls.is_mret   = 1'b1;
          else                            o_inst_invalid  = 1'b1;
        end else if (o_funct3 == 3'b100) begin
          o_inst_invalid = 1'b1;
        end else begin
          o_cls.is_csr = 1'b1;
        end
      end
      default: o_inst_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_fetch_decode_exec.sv
// Single-cycle RV32I + Zicsr front end: PC register, decode, ALU and next-PC.
module rv32_fetch_decode_exec
  import rv32_fetch_decode_exec_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PKG_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic [31:0] imem_rdata,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] csr_rdata,
  input  logic [31:0] mepc,
  input  logic [31:0] mtvec,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [11:0] csr_addr,
  output logic [31:0] imm,
  output logic        is_load,
  output logic        is_store,
  output logic        is_ecall,
  output logic        inst_invalid,
  output logic [31:0] result,
  output logic        reg_write_en,
  output logic [31:0] next_pc,
  output logic        csr_we,
  output logic [31:0] csr_wdata
);

  logic [31:0] r_pc;
  dec_class_t  w_cls;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_alu_b;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu;
  logic        w_taken;
  logic [31:0] w_csr_src;
  logic [31:0] w_jalr_sum;

  // PC register: reset has priority, otherwise step only when the core advances
  always_ff @(posedge clk) begin
    if (rst)          r_pc <= RESET_PC;
    else if (advance) r_pc <= next_pc;
  end

  assign pc         = r_pc;
  assign inst       = imem_rdata;
  assign w_pc_plus4 = r_pc + 32'd4;

  rv32_fetch_decode_exec_decoder u_decoder (
    .i_inst         (imem_rdata),
    .o_opcode       (opcode),
    .o_funct3       (funct3),
    .o_funct7       (funct7),
    .o_rs1_addr     (rs1_addr),
    .o_rs2_addr     (rs2_addr),
    .o_rd_addr      (rd_addr),
    .o_csr_addr     (csr_addr),
    .o_imm          (imm),
    .o_cls          (w_cls),
    .o_inst_invalid (inst_invalid)
  );

  assign is_load  = w_cls.is_load;
  assign is_store = w_cls.is_store;
  assign is_ecall = (imem_rdata == INST_ECALL);

  // Integer ALU shared by OP and OP-IMM; SUB only exists in the register form
  always_comb begin
    w_alu_b = w_cls.is_op ? rs2_data : imm;
    w_shamt = w_alu_b[4:0];
    w_alu   = 32'd0;
    case (funct3)
      3'b000: w_alu = (w_cls.is_op && funct7[5]) ? (rs1_data - w_alu_b) : (rs1_data + w_alu_b);
      3'b001: w_alu = rs1_data << w_shamt;
      3'b010: w_alu = {31'd0, $signed(rs1_data) < $signed(w_alu_b)};
      3'b011: w_alu = {31'd0, rs1_data < w_alu_b};
      3'b100: w_alu = rs1_data ^ w_alu_b;
      3'b101: w_alu = funct7[5] ? 32'($signed(rs1_data) >>> w_shamt) : (rs1_data >> w_shamt);
      3'b110: w_alu = rs1_data | w_alu_b;
      default: w_alu = rs1_data & w_alu_b;
    endcase
  end

  // Branch condition from funct3; unassigned funct3 values never reach here as valid
  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000: w_taken = (rs1_data == rs2_data);
      3'b001: w_taken = (rs1_data != rs2_data);
      3'b100: w_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101: w_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110: w_taken = (rs1_data <  rs2_data);
      3'b111: w_taken = (rs1_data >= rs2_data);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_jalr_sum = rs1_data + imm;

  // Result mux: link address, effective address, ALU value or CSR old value
  always_comb begin
    result = 32'd0;
    if      (w_cls.is_lui)                     result = imm;
    else if (w_cls.is_auipc)                   result = r_pc + imm;
    else if (w_cls.is_jal || w_cls.is_jalr)    result = w_pc_plus4;
    else if (w_cls.is_load || w_cls.is_store)  result = rs1_data + imm;
    else if (w_cls.is_op || w_cls.is_op_imm)   result = w_alu;
    else if (w_cls.is_csr)                     result = csr_rdata;
  end

  // Next-PC selection; an invalid encoding falls through to pc+4
  always_comb begin
    next_pc = w_pc_plus4;
    if      (w_cls.is_jal)               next_pc = r_pc + imm;
    else if (w_cls.is_jalr)              next_pc = {w_jalr_sum[31:1], 1'b0};
    else if (w_cls.is_branch && w_taken) next_pc = r_pc + imm;
    else if (w_cls.is_ecall)             next_pc = mtvec;
    else if (w_cls.is_mret)              next_pc = mepc;
  end

  // Writeback request; class flags are already cleared for invalid encodings
  always_comb begin
    reg_write_en = (w_cls.is_lui | w_cls.is_auipc | w_cls.is_jal | w_cls.is_jalr |
                    w_cls.is_load | w_cls.is_op | w_cls.is_op_imm | w_cls.is_csr) &&
                   (rd_addr != 5'd0);
  end

  // CSR write value; funct3[2] selects the zimm form, funct3[1:0] the W/S/C flavour
  always_comb begin
    w_csr_src = funct3[2] ? {27'd0, rs1_addr} : rs1_data;
    csr_wdata = 32'd0;
    case (funct3[1:0])
      2'b01:   csr_wdata = w_csr_src;
      2'b10:   csr_wdata = csr_rdata | w_csr_src;
      2'b11:   csr_wdata = csr_rdata & ~w_csr_src;
      default: csr_wdata = 32'd0;
    endcase
    // Set/clear with a zero rs1 field is a pure read and must not write
    csr_we = w_cls.is_csr && ((funct3[1:0] == 2'b01) || (rs1_addr != 5'd0));
  end

endmodule

// File: tb/tb_rv32_fetch_decode_exec.sv
// Directed testbench for rv32_fetch_decode_exec with hand-computed expectations.
module tb_rv32_fetch_decode_exec;

  logic        clk;
  logic        rst;
  logic        advance;
  logic [31:0] imem_rdata;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] csr_rdata;
  logic [31:0] mepc;
  logic [31:0] mtvec;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [11:0] csr_addr;
  logic [31:0] imm;
  logic        is_load;
  logic        is_store;
  logic        is_ecall;
  logic        inst_invalid;
  logic [31:0] result;
  logic        reg_write_en;
  logic [31:0] next_pc;
  logic        csr_we;
  logic [31:0] csr_wdata;

  int n_compared;
  int n_mismatched;

  localparam logic [31:0] P = 32'h8000_0004;

  rv32_fetch_decode_exec #(.RESET_PC(32'h8000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .advance      (advance),
    .imem_rdata   (imem_rdata),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .csr_rdata    (csr_rdata),
    .mepc         (mepc),
    .mtvec        (mtvec),
    .pc           (pc),
    .inst         (inst),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rd_addr      (rd_addr),
    .csr_addr     (csr_addr),
    .imm          (imm),
    .is_load      (is_load),
    .is_store     (is_store),
    .is_ecall     (is_ecall),
    .inst_invalid (inst_invalid),
    .result       (result),
    .reg_write_en (reg_write_en),
    .next_pc      (next_pc),
    .csr_we       (csr_we),
    .csr_wdata    (csr_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive one instruction with its operands and let the combinational paths settle
  task automatic apply(input string tag, input logic [31:0] i_word, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c);
    imem_rdata = i_word;
    rs1_data   = a;
    rs2_data   = b;
    csr_rdata  = c;
    #2;
    $display("txn %-8s inst=%08h pc=%08h result=%08h next_pc=%08h rwe=%0b cwe=%0b",
             tag, inst, pc, result, next_pc, reg_write_en, csr_we);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst        = 1'b1;
    advance    = 1'b1;
    imem_rdata = 32'h0050_0093;   // addi x1,x0,5
    rs1_data   = 32'd0;
    rs2_data   = 32'd0;
    csr_rdata  = 32'd0;
    mepc       = 32'h8000_0010;
    mtvec      = 32'h8000_0400;

    // Reset and the first addi
    @(posedge clk); #1;
    check_value("rst_pc", pc, 32'h8000_0000);
    @(posedge clk); #1;
    check_value("rst_pc_hold", pc, 32'h8000_0000);
    check_value("addi_result", result, 32'd5);
    check_value("addi_rd", {27'd0, rd_addr}, 32'd1);
    check_value("addi_rwe", {31'd0, reg_write_en}, 32'd1);
    check_value("addi_npc", next_pc, 32'h8000_0004);
    check_value("addi_inst", inst, 32'h0050_0093);
    rst = 1'b0;
    @(posedge clk); #1;
    check_value("adv_pc", pc, P);
    advance = 1'b0;

    // Stall: pc holds for three edges
    repeat (3) @(posedge clk);
    #1;
    check_value("stall_pc", pc, P);

    // Branches
    apply("beq_t", 32'h0020_8463, 32'd7, 32'd7, 32'd0);
    check_value("beq_t_npc", next_pc, P + 32'd8);
    check_value("beq_imm", imm, 32'd8);
    check_value("beq_rwe", {31'd0, reg_write_en}, 32'd0);
    apply("beq_n", 32'h0020_8463, 32'd7, 32'd8, 32'd0);
    check_value("beq_n_npc", next_pc, P + 32'd4);
    apply("blt", 32'h0020_C463, 32'hFFFF_FFFF, 32'd1, 32'd0);
    check_value("blt_npc", next_pc, P + 32'd8);
    apply("bltu", 32'h0020_E463, 32'hFFFF_FFFF, 32'd1, 32'd0);
    check_value("bltu_npc", next_pc, P + 32'd4);

    // Jumps
    apply("jalr", 32'h0041_00E7, 32'h8000_1003, 32'd0, 32'd0);
    check_value("jalr_npc", next_pc, 32'h8000_1006);
    check_value("jalr_res", result, P + 32'd4);
    check_value("jalr_rwe", {31'd0, reg_write_en}, 32'd1);
    apply("jal", 32'h0100_00EF, 32'd0, 32'd0, 32'd0);
    check_value("jal_npc", next_pc, P + 32'd16);
    check_value("jal_res", result, P + 32'd4);

    // Upper-immediate forms
    apply("lui", 32'h1234_52B7, 32'd0, 32'd0, 32'd0);
    check_value("lui_res", result, 32'h1234_5000);
    apply("auipc", 32'h0000_1297, 32'd0, 32'd0, 32'd0);
    check_value("auipc_res", result, 32'h8000_1004);

    // Register/immediate ALU
    apply("sub", 32'h4020_81B3, 32'd5, 32'd7, 32'd0);
    check_value("sub_res", result, 32'hFFFF_FFFE);
    apply("srai", 32'h4040_D193, 32'h8000_0000, 32'd0, 32'd0);
    check_value("srai_res", result, 32'hF800_0000);

    // Store address
    apply("sw", 32'h0020_A423, 32'h8000_0100, 32'hDEAD_BEEF, 32'd0);
    check_value("sw_res", result, 32'h8000_0108);
    check_value("sw_store", {31'd0, is_store}, 32'd1);
    check_value("sw_load", {31'd0, is_load}, 32'd0);
    check_value("sw_rwe", {31'd0, reg_write_en}, 32'd0);

    // CSR ops
    apply("csrrs0", 32'h3050_22F3, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678);
    check_value("csrrs0_we", {31'd0, csr_we}, 32'd0);
    check_value("csrrs0_res", result, 32'h1234_5678);
    check_value("csrrs0_rwe", {31'd0, reg_write_en}, 32'd1);
    check_value("csrrs0_addr", {20'd0, csr_addr}, 32'h305);
    apply("csrrw", 32'h3053_12F3, 32'hA5A5_0000, 32'd0, 32'h1234_5678);
    check_value("csrrw_we", {31'd0, csr_we}, 32'd1);
    check_value("csrrw_wd", csr_wdata, 32'hA5A5_0000);
    apply("csrrci", 32'h3004_7073, 32'hFFFF_FFFF, 32'd0, 32'h0000_188F);
    check_value("csrrci_we", {31'd0, csr_we}, 32'd1);
    check_value("csrrci_wd", csr_wdata, 32'h0000_1887);
    check_value("csrrci_rwe", {31'd0, reg_write_en}, 32'd0);

    // System
    apply("ecall", 32'h0000_0073, 32'd0, 32'd0, 32'd0);
    check_value("ecall_flag", {31'd0, is_ecall}, 32'd1);
    check_value("ecall_npc", next_pc, 32'h8000_0400);
    apply("mret", 32'h3020_0073, 32'd0, 32'd0, 32'd0);
    check_value("mret_npc", next_pc, 32'h8000_0010);
    check_value("mret_ecall", {31'd0, is_ecall}, 32'd0);
    apply("ebreak", 32'h0010_0073, 32'd0, 32'd0, 32'd0);
    check_value("ebreak_npc", next_pc, P + 32'd4);

    // Invalid encoding
    apply("invalid", 32'hFFFF_FFFF, 32'h1111_1111, 32'd0, 32'd0);
    check_value("inv_flag", {31'd0, inst_invalid}, 32'd1);
    check_value("inv_npc", next_pc, P + 32'd4);
    check_value("inv_rwe", {31'd0, reg_write_en}, 32'd0);
    check_value("inv_cwe", {31'd0, csr_we}, 32'd0);
    check_value("inv_store", {31'd0, is_store}, 32'd0);

    // Resume fetch
    apply("addi2", 32'h0050_0093, 32'd0, 32'd0, 32'd0);
    advance = 1'b1;
    @(posedge clk); #1;
    check_value("resume_pc", pc, P + 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
